// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0]  NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned  INSTR_BYTES = 4;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC computation for the held instruction: sequential or branch target,
// plus an alignment flag for the resulting address.
module next_pc_gen
    import fetch_pkg::*;
(
    input  logic [63:0] instr_pc,
    input  logic        branch_taken,
    input  logic [63:0] branch_imm,
    output logic [63:0] next_pc,
    output logic        misaligned
);

    // Modulo-2^64 add; the immediate is two's complement so a plain add covers both directions.
    always_comb begin
        next_pc = branch_taken ? (instr_pc + branch_imm) : (instr_pc + 64'(INSTR_BYTES));
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time,
// holds the returned word for decode and advances the PC on accept.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [63:0] instr_pc,
    input  logic        branch_taken,
    input  logic [63:0] branch_imm,
    output logic        fetch_fault
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  next_pc;
    logic         misaligned;

    next_pc_gen u_next_pc_gen (
        .instr_pc     (instr_pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    assign imem_req_addr = pc;

    // Fetch FSM; the valid/fault outputs are registered alongside the state so
    // they never depend combinationally on any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            instr_out      <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_out   <= imem_rsp_data;
                        instr_pc    <= pc;
                        state       <= HOLD;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (misaligned) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            pc             <= next_pc;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state          <= FAULT;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                    fetch_fault    <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural memory and PC model
// drive randomized stalls and branches and compare every visible output.
module tb_instr_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_imm = '0;
    logic        fetch_fault;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_hold = -1;
    logic [63:0] exp_pc;
    logic [31:0] seed;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .branch_imm     (branch_imm),
        .fetch_fault    (fetch_fault)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ seed;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
        check("req_seen", 64'(imem_req_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_PC);
        check({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
        check({tag, "_instr_out"}, 64'(instr_out), 64'(NOP));
        check({tag, "_instr_pc"}, instr_pc, RST_PC);
        check({tag, "_fault"}, 64'(fetch_fault), 64'd0);
    endtask

    // One full request/response/accept transaction against the model PC.
    task automatic fetch_one(input int req_stall, input int rsp_delay, input int hold_stall,
                             input bit taken, input logic [63:0] imm, input bit chk_rate);
        logic [63:0] nxt;
        logic [31:0] w;
        wait_req();
        check("req_addr", imem_req_addr, exp_pc);
        imem_req_ready = 1'b0;
        for (int i = 0; i < req_stall; i++) begin
            tick();
            check("req_hold_valid", 64'(imem_req_valid), 64'd1);
            check("req_hold_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("req_drop", 64'(imem_req_valid), 64'd0);
        for (int i = 0; i < rsp_delay; i++) begin
            tick();
            check("wait_no_instr", 64'(instr_valid), 64'd0);
            check("wait_no_req", 64'(imem_req_valid), 64'd0);
        end
        w = mem_word(exp_pc);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = w;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_instr", 64'(instr_out), 64'(w));
        check("hold_pc", instr_pc, exp_pc);
        if (chk_rate && last_hold >= 0)
            check("rate", 64'(cyc - last_hold), 64'd3);
        last_hold = cyc;
        for (int i = 0; i < hold_stall; i++) begin
            branch_taken = 1'($urandom);
            branch_imm   = {$urandom, $urandom};
            tick();
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_instr", 64'(instr_out), 64'(w));
            check("stall_pc", instr_pc, exp_pc);
            check("stall_no_req", 64'(imem_req_valid), 64'd0);
        end
        instr_ready  = 1'b1;
        branch_taken = taken;
        branch_imm   = imm;
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'($urandom);
        branch_imm   = {$urandom, $urandom};
        nxt = taken ? exp_pc + imm : exp_pc + 64'd4;
        if (nxt[1:0] != 2'b00) begin
            check("fault_set", 64'(fetch_fault), 64'd1);
            check("fault_instr_valid", 64'(instr_valid), 64'd0);
            check("fault_req_valid", 64'(imem_req_valid), 64'd0);
            imem_req_ready = 1'b1;
            instr_ready    = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                check("fault_no_req", 64'(imem_req_valid), 64'd0);
                check("fault_sticky", 64'(fetch_fault), 64'd1);
            end
            imem_req_ready = 1'b0;
            instr_ready    = 1'b0;
        end else begin
            check("next_fault", 64'(fetch_fault), 64'd0);
            check("next_instr_valid", 64'(instr_valid), 64'd0);
            check("next_req_valid", 64'(imem_req_valid), 64'd1);
            check("next_req_addr", imem_req_addr, nxt);
            exp_pc = nxt;
        end
    endtask

    initial begin
        logic [63:0] imm;
        bit          tk;
        seed   = $urandom;
        exp_pc = RST_PC;

        // Reset state, then release between edges.
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("pre_first_edge_req", 64'(imem_req_valid), 64'd0);
        tick();
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, RST_PC);

        // Best-case sequential fetches: 0x1000, 0x1004, 0x1008, 0x100C.
        for (int i = 0; i < 4; i++) fetch_one(0, 0, 0, 1'b0, 64'd0, 1'b1);
        // Backward branch from 0x1010 by -8 lands on 0x1008.
        check("model_pc_1010", exp_pc, 64'h1010);
        fetch_one(0, 0, 0, 1'b1, -64'sd8, 1'b1);
        check("branch_back", imem_req_addr, 64'h1008);
        // Long request and consumer stalls.
        fetch_one(5, 1, 4, 1'b0, 64'd0, 1'b0);

        // Randomized aligned traffic.
        for (int n = 0; n < 40; n++) begin
            tk  = 1'($urandom);
            imm = 64'($urandom_range(0, 32) * 4) - 64'd64;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), tk, imm, 1'b0);
        end

        // Wraparound at the top of the address space.
        fetch_one(0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC - exp_pc, 1'b0);
        check("top_addr", exp_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(0, 0, 0, 1'b0, 64'd0, 1'b0);
        check("wrap_addr", imem_req_addr, 64'h0);
        fetch_one(1, 0, 1, 1'b0, 64'd0, 1'b0);

        // Asynchronous reset while waiting for a response.
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        tick();
        rst_n     = 1'b1;
        exp_pc    = RST_PC;
        last_hold = -1;
        tick();
        check("refetch_valid", 64'(imem_req_valid), 64'd1);
        check("refetch_addr", imem_req_addr, RST_PC);

        // Misaligned branch target from 0x1000 faults permanently.
        fetch_one(0, 0, 0, 1'b1, 64'd6, 1'b0);
        check("fault_pc_kept", imem_req_addr, RST_PC);

        // Reset clears the fault and fetch resumes.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("fault_reset");
        tick();
        rst_n  = 1'b1;
        exp_pc = RST_PC;
        fetch_one(0, 0, 0, 1'b0, 64'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
